// File: rtl/r_type_encoder.sv
// Encodes ALUOp requests into MIPS R-type words and queues them in a small
// circular FIFO with valid/ready handshakes on the request and word sides.
module r_type_encoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_sel,
   input  logic [4:0]       rs,
   input  logic [4:0]       rt,
   input  logic [4:0]       rd,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [31:0]      instr,
   output logic             err_illegal,
   output logic [CNT_W-1:0] issued_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic [31:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic        legal;
   logic [5:0]  funct;
   logic        accept;
   logic        push;
   logic        pop;
   logic [31:0] word;

   // Handshake rule on both sides: a transfer happens on a rising edge where
   // valid and ready are both high; ready never depends on the partner's valid.
   always_comb begin
      legal = 1'b1;
      funct = 6'h00;
      case (op_sel)
         OP_AND:  funct = 6'h24;
         OP_OR:   funct = 6'h25;
         OP_ADD:  funct = 6'h20;
         OP_SUB:  funct = 6'h22;
         OP_SLT:  funct = 6'h2A;
         default: legal = 1'b0;
      endcase
   end

   assign word        = {6'b000000, rs, rt, rd, 5'b00000, funct};
   assign op_ready    = (count != FULL_CNT);
   assign instr_valid = (count != '0);
   assign accept      = op_valid && op_ready;
   assign push        = accept && legal;
   assign pop         = instr_valid && instr_ready;

   // Output is forced to zero when empty so stale entries never leak out.
   assign instr = instr_valid ? mem[rd_ptr] : 32'h0;

   always_ff @(posedge clk) begin
      if (push && rst_n) begin
         mem[wr_ptr] <= word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         err_illegal  <= 1'b0;
         issued_count <= '0;
      end else begin
         err_illegal <= accept && !legal;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr       <= rd_ptr + AW'(1);
            issued_count <= issued_count + CNT_W'(1);
         end
         if (push && !pop) begin
            count <= count + (AW+1)'(1);
         end else if (pop && !push) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule
